// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port, with a wait-state timeout and an illegal-opcode trap.
module multi_cycle_control #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                SignExtend,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                IllegalOp,
  output logic                BusError
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_IMM_LO = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_IMM_HI = OPCODE_W'(6'b001111);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_LUI   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_XOR   = 4'd8;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_RTYPE, S_RWB, S_IMMEX, S_IWB, S_MEMADDR,
    S_MEMRD, S_LWB, S_MEMWR, S_BRANCH, S_JUMP, S_TRAP, S_HALT
  } state_t;

  state_t           state_r;
  state_t           done_state_s;
  state_t           sel_s;
  logic [CNT_W-1:0] cnt_r;
  logic             illegal_r;
  logic             bus_err_r;
  logic [3:0]       aluop_s;

  // Successor of a memory-wait state once MemReady completes the access.
  always_comb begin
    done_state_s = S_FETCH;
    case (state_r)
      S_FETCH: done_state_s = S_DECODE;
      S_MEMRD: done_state_s = S_LWB;
      default: done_state_s = S_FETCH;
    endcase
  end

  // State register, wait-state counter and sticky error flags.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r   <= S_FETCH;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      cnt_r <= '0;
      case (state_r)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (MemReady) begin
            state_r <= done_state_s;
          end else if (cnt_r == CNT_LAST) begin
            state_r   <= S_HALT;
            bus_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (Opcode == OP_R) begin
            state_r <= S_RTYPE;
          end else if (Opcode == OP_LW || Opcode == OP_SW) begin
            state_r <= S_MEMADDR;
          end else if (Opcode == OP_BEQ) begin
            state_r <= S_BRANCH;
          end else if (Opcode == OP_J) begin
            state_r <= S_JUMP;
          end else if (Opcode >= OP_IMM_LO && Opcode <= OP_IMM_HI) begin
            state_r <= S_IMMEX;
          end else begin
            state_r   <= S_TRAP;
            illegal_r <= 1'b1;
          end
        end
        S_RTYPE:   state_r <= S_RWB;
        S_IMMEX:   state_r <= S_IWB;
        S_MEMADDR: state_r <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_RWB, S_IWB, S_LWB, S_BRANCH, S_JUMP: state_r <= S_FETCH;
        S_TRAP:    state_r <= S_HALT;
        S_HALT:    state_r <= S_HALT;
        default:   state_r <= S_HALT;
      endcase
    end
  end

  // Immediate-group ALU operation from the low opcode bits.
  always_comb begin
    aluop_s = ALU_ADD;
    case (Opcode[2:0])
      3'b000, 3'b001: aluop_s = ALU_ADD;
      3'b010:         aluop_s = ALU_SLT;
      3'b011:         aluop_s = ALU_SLTU;
      3'b100:         aluop_s = ALU_AND;
      3'b101:         aluop_s = ALU_OR;
      3'b110:         aluop_s = ALU_XOR;
      3'b111:         aluop_s = ALU_LUI;
      default:        aluop_s = ALU_ADD;
    endcase
  end

  // Holding Reset decodes as HALT so every strobe drops immediately.
  assign sel_s = Reset ? S_HALT : state_r;

  // Moore output decode; only IRWrite/PCWrite in fetch look at MemReady.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    PCSource    = 2'd0;
    SignExtend  = 1'b0;
    ALUOp       = ALUOP_W'(ALU_ADD);
    case (sel_s)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB    = 2'd3;
        SignExtend = 1'b1;
      end
      S_RTYPE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(ALU_FUNCT);
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_IMMEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ALUOp      = ALUOP_W'(aluop_s);
        SignExtend = ~Opcode[2];
      end
      S_IWB: RegWrite = 1'b1;
      S_MEMADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        SignExtend = 1'b1;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_LWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(ALU_SUB);
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      default: PCWrite = 1'b0;
    endcase
  end

  assign IllegalOp = illegal_r;
  assign BusError  = bus_err_r;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control (TIMEOUT=4); expected output
// vectors are queued per cycle and compared against the DUT outputs mid-cycle.
module tb_multi_cycle_control;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, SignExtend, IllegalOp, BusError;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp;

  multi_cycle_control #(.OPCODE_W(6), .ALUOP_W(4), .TIMEOUT(4)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .SignExtend(SignExtend), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .BusError(BusError)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];
  logic        ill_e = 1'b0;
  logic        be_e  = 1'b0;

  // {pcw,pcwc,iord,mrd,mwr,irw,m2r,rdst,rw,asa,asb,pcs,se,aluop,ill,be}
  function automatic logic [20:0] mk(input logic pcw, pcwc, iord, mrd, mwr, irw, m2r,
                                     rdst, rw, asa, input logic [1:0] asb, pcs,
                                     input logic se, input logic [3:0] aop);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, se, aop, ill_e, be_e};
  endfunction

  function automatic logic [20:0] e_zero();  return mk(0,0,0,0,0,0,0,0,0,0,2'd0,2'd0,0,4'd0); endfunction
  function automatic logic [20:0] e_fetch(input logic r);
    return mk(r,0,0,1,0,r,0,0,0,0,2'd1,2'd0,0,4'd0);
  endfunction
  function automatic logic [20:0] e_decode();  return mk(0,0,0,0,0,0,0,0,0,0,2'd3,2'd0,1,4'd0); endfunction
  function automatic logic [20:0] e_memaddr(); return mk(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,1,4'd0); endfunction
  function automatic logic [20:0] e_immex(input logic [3:0] aop, input logic se);
    return mk(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,se,aop);
  endfunction

  // One cycle: drive inputs, queue the expectation, compare mid-cycle, advance a clock.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic rdy, input logic [20:0] e);
    logic [20:0] obs;
    logic [20:0] want;
    Reset = rst; Opcode = op; MemReady = rdy;
    exp_q.push_back(e);
    #3;
    obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, SignExtend, ALUOp, IllegalOp, BusError};
    want = exp_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    Reset = 1'b1; Opcode = 6'd0; MemReady = 1'b0;
    @(posedge CLK); #1;
    cyc("reset", 1'b1, 6'd0, 1'b1, e_zero());

    // R-type, ready tied high
    cyc("r_fetch",  1'b0, 6'b000000, 1'b1, e_fetch(1'b1));
    cyc("r_decode", 1'b0, 6'b000000, 1'b1, e_decode());
    cyc("r_exec",   1'b0, 6'b000000, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2'd0,2'd0,0,4'd2));
    cyc("r_wb",     1'b0, 6'b000000, 1'b1, mk(0,0,0,0,0,0,0,1,1,0,2'd0,2'd0,0,4'd0));

    // LW with three wait cycles in MEMRD
    cyc("lw_fetch",  1'b0, 6'b100011, 1'b1, e_fetch(1'b1));
    cyc("lw_decode", 1'b0, 6'b100011, 1'b1, e_decode());
    cyc("lw_addr",   1'b0, 6'b100011, 1'b1, e_memaddr());
    for (int i = 0; i < 3; i++)
      cyc("lw_rd_wait", 1'b0, 6'b000000, 1'b0, mk(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,0,4'd0));
    cyc("lw_rd_done", 1'b0, 6'b000000, 1'b1, mk(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,0,4'd0));
    cyc("lw_wb",      1'b0, 6'b000000, 1'b1, mk(0,0,0,0,0,0,1,0,1,0,2'd0,2'd0,0,4'd0));

    // ORI and SLTI immediate paths
    cyc("ori_fetch",  1'b0, 6'b001101, 1'b1, e_fetch(1'b1));
    cyc("ori_decode", 1'b0, 6'b001101, 1'b1, e_decode());
    cyc("ori_exec",   1'b0, 6'b001101, 1'b1, e_immex(4'd3, 1'b0));
    cyc("ori_wb",     1'b0, 6'b001101, 1'b1, mk(0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,0,4'd0));
    cyc("slti_fetch", 1'b0, 6'b001010, 1'b1, e_fetch(1'b1));
    cyc("slti_decode",1'b0, 6'b001010, 1'b1, e_decode());
    cyc("slti_exec",  1'b0, 6'b001010, 1'b1, e_immex(4'd6, 1'b1));
    cyc("slti_wb",    1'b0, 6'b001010, 1'b1, mk(0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,0,4'd0));
    cyc("lui_fetch",  1'b0, 6'b001111, 1'b1, e_fetch(1'b1));
    cyc("lui_decode", 1'b0, 6'b001111, 1'b1, e_decode());
    cyc("lui_exec",   1'b0, 6'b001111, 1'b1, e_immex(4'd5, 1'b0));
    cyc("lui_wb",     1'b0, 6'b111111, 1'b1, mk(0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,0,4'd0));

    // BEQ and J
    cyc("beq_fetch",  1'b0, 6'b000100, 1'b1, e_fetch(1'b1));
    cyc("beq_decode", 1'b0, 6'b000100, 1'b1, e_decode());
    cyc("beq_exec",   1'b0, 6'b000100, 1'b1, mk(0,1,0,0,0,0,0,0,0,1,2'd0,2'd1,0,4'd1));
    cyc("j_fetch",    1'b0, 6'b000010, 1'b1, e_fetch(1'b1));
    cyc("j_decode",   1'b0, 6'b000010, 1'b1, e_decode());
    cyc("j_exec",     1'b0, 6'b000010, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,2'd0,2'd2,0,4'd0));

    // SW interrupted by Reset while MEMWR waits
    cyc("sw_fetch",  1'b0, 6'b101011, 1'b1, e_fetch(1'b1));
    cyc("sw_decode", 1'b0, 6'b101011, 1'b1, e_decode());
    cyc("sw_addr",   1'b0, 6'b101011, 1'b1, e_memaddr());
    cyc("sw_wr_wait",1'b0, 6'b101011, 1'b0, mk(0,0,1,0,1,0,0,0,0,0,2'd0,2'd0,0,4'd0));
    cyc("sw_reset",  1'b1, 6'b101011, 1'b0, e_zero());
    cyc("sw_after",  1'b0, 6'b000000, 1'b0, e_fetch(1'b0));
    cyc("sw_after2", 1'b0, 6'b000000, 1'b1, e_fetch(1'b1));
    cyc("sw_decode2",1'b0, 6'b000010, 1'b1, e_decode());
    cyc("sw_jump",   1'b0, 6'b000010, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,2'd0,2'd2,0,4'd0));

    // Fetch completes on the last allowed wait cycle: no error
    for (int i = 0; i < 3; i++)
      cyc("to_edge_wait", 1'b0, 6'b000000, 1'b0, e_fetch(1'b0));
    cyc("to_edge_ready", 1'b0, 6'b000000, 1'b1, e_fetch(1'b1));
    cyc("to_edge_decode",1'b0, 6'b000000, 1'b1, e_decode());
    cyc("to_edge_exec",  1'b0, 6'b000000, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2'd0,2'd0,0,4'd2));
    cyc("to_edge_wb",    1'b0, 6'b000000, 1'b1, mk(0,0,0,0,0,0,0,1,1,0,2'd0,2'd0,0,4'd0));

    // Illegal opcode trap, sticky until Reset
    cyc("trap_fetch",  1'b0, 6'b111111, 1'b1, e_fetch(1'b1));
    cyc("trap_decode", 1'b0, 6'b111111, 1'b1, e_decode());
    ill_e = 1'b1;
    cyc("trap_state",  1'b0, 6'b000000, 1'b1, e_zero());
    for (int i = 0; i < 3; i++)
      cyc("trap_halt", 1'b0, 6'b100011, 1'b1, e_zero());
    cyc("trap_reset",  1'b1, 6'b000000, 1'b1, e_zero());
    ill_e = 1'b0;
    cyc("trap_cleared",1'b0, 6'b000000, 1'b1, e_fetch(1'b1));
    cyc("trap_decode2",1'b0, 6'b000100, 1'b1, e_decode());
    cyc("trap_beq",    1'b0, 6'b000100, 1'b1, mk(0,1,0,0,0,0,0,0,0,1,2'd0,2'd1,0,4'd1));

    // Fetch timeout: four waits with MemReady low raise BusError
    for (int i = 0; i < 4; i++)
      cyc("bus_wait", 1'b0, 6'b000000, 1'b0, e_fetch(1'b0));
    be_e = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("bus_halt", 1'b0, 6'b000000, 1'b1, e_zero());
    cyc("bus_reset", 1'b1, 6'b000000, 1'b1, e_zero());
    be_e = 1'b0;
    cyc("bus_cleared", 1'b0, 6'b000000, 1'b1, e_fetch(1'b1));

    // MEMRD timeout also raises BusError
    cyc("lwto_decode", 1'b0, 6'b100011, 1'b1, e_decode());
    cyc("lwto_addr",   1'b0, 6'b100011, 1'b1, e_memaddr());
    for (int i = 0; i < 4; i++)
      cyc("lwto_wait", 1'b0, 6'b100011, 1'b0, mk(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,0,4'd0));
    be_e = 1'b1;
    cyc("lwto_halt", 1'b0, 6'b100011, 1'b1, e_zero());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
